// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: counter encodings and FSM state codes.
package branch_predictor_pkg;

    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    typedef enum logic {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_e;

endpackage

// File: rtl/branch_predictor_sat_ctr.sv
// Combinational next value of a 2-bit saturating direction counter.
module bp_sat_ctr
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, table-invalidation FSM and
// resolved-branch / mispredict performance counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int         ENTRIES  = 64,
    parameter int         IDX_W    = $clog2(ENTRIES),
    parameter logic [1:0] CTR_INIT = 2'b10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        lk_valid,
    input  logic        lk_stall,
    input  logic [31:0] lk_pc,
    output logic        pred_valid,
    output logic        predict,
    output logic [31:0] predict_target,
    output logic        ready,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_uncond,
    input  logic        upd_mispredict,
    output logic [31:0] upd_count,
    output logic [31:0] mispred_count
);

    localparam int TAG_W = 32 - IDX_W - 2;

    bp_state_e        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             tbl_valid_q  [ENTRIES];
    logic [TAG_W-1:0] tbl_tag_q    [ENTRIES];
    logic [29:0]      tbl_target_q [ENTRIES];
    logic [1:0]       tbl_ctr_q    [ENTRIES];
    logic             tbl_uncond_q [ENTRIES];

    logic        pred_valid_q, pred_valid_d;
    logic        predict_q, predict_d;
    logic [31:0] predict_target_q, predict_target_d;
    logic [31:0] upd_count_q, upd_count_d;
    logic [31:0] mispred_count_q, mispred_count_d;

    // ---------------- FSM: state register / next state / outputs ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BP_INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (flush) begin
            state_d = BP_INIT;
            idx_d   = '0;
        end else if (state_q == BP_INIT) begin
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(ENTRIES - 1)) state_d = BP_RUN;
        end
    end

    logic init_clr;
    always_comb begin
        ready    = (state_q == BP_RUN);
        init_clr = (state_q == BP_INIT);
    end

    // ---------------- lookup ----------------
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit, lk_taken;

    always_comb begin
        lk_idx   = lk_pc[IDX_W+1:2];
        lk_tag   = lk_pc[31:IDX_W+2];
        lk_hit   = (state_q == BP_RUN) && tbl_valid_q[lk_idx] && (tbl_tag_q[lk_idx] == lk_tag);
        lk_taken = lk_hit && (tbl_ctr_q[lk_idx][1] || tbl_uncond_q[lk_idx]);

        pred_valid_d     = pred_valid_q;
        predict_d        = predict_q;
        predict_target_d = predict_target_q;
        if (!lk_stall) begin
            pred_valid_d     = lk_valid;
            predict_d        = lk_valid && lk_taken;
            predict_target_d = (lk_valid && lk_taken) ? {tbl_target_q[lk_idx], 2'b00} : 32'd0;
        end
    end

    // ---------------- update ----------------
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit, upd_en;
    logic [1:0]       upd_ctr_sat;
    logic             wr_en;
    logic [29:0]      wr_target;
    logic [1:0]       wr_ctr;
    logic             wr_uncond;

    always_comb begin
        upd_idx = upd_pc[IDX_W+1:2];
        upd_tag = upd_pc[31:IDX_W+2];
        upd_hit = tbl_valid_q[upd_idx] && (tbl_tag_q[upd_idx] == upd_tag);
    end

    bp_sat_ctr u_sat_ctr (
        .ctr      (tbl_ctr_q[upd_idx]),
        .taken    (upd_taken),
        .ctr_next (upd_ctr_sat)
    );

    always_comb begin
        // Flush outranks a same-cycle resolution: it is dropped and not counted.
        upd_en    = upd_valid && (state_q == BP_RUN) && !flush;
        wr_en     = 1'b0;
        wr_target = tbl_target_q[upd_idx];
        wr_ctr    = tbl_ctr_q[upd_idx];
        wr_uncond = tbl_uncond_q[upd_idx];
        if (upd_en) begin
            if (upd_hit) begin
                wr_en = 1'b1;
                if (upd_uncond) begin
                    wr_target = upd_target[31:2];
                    wr_ctr    = CTR_ST;
                end else begin
                    wr_ctr = upd_ctr_sat;
                    if (upd_taken) wr_target = upd_target[31:2];
                end
            end else if (upd_taken || upd_uncond) begin
                wr_en     = 1'b1;
                wr_target = upd_target[31:2];
                wr_ctr    = upd_uncond ? CTR_ST : CTR_INIT;
                wr_uncond = upd_uncond;
            end
        end
        upd_count_d     = upd_count_q + (upd_en ? 32'd1 : 32'd0);
        mispred_count_d = mispred_count_q + ((upd_en && upd_mispredict) ? 32'd1 : 32'd0);
    end

    // Table storage: no reset needed, INIT invalidates every entry before use.
    always_ff @(posedge clk) begin
        if (init_clr) begin
            tbl_valid_q[idx_q] <= 1'b0;
        end else if (wr_en) begin
            tbl_valid_q[upd_idx]  <= 1'b1;
            tbl_tag_q[upd_idx]    <= upd_tag;
            tbl_target_q[upd_idx] <= wr_target;
            tbl_ctr_q[upd_idx]    <= wr_ctr;
            tbl_uncond_q[upd_idx] <= wr_uncond;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid_q     <= 1'b0;
            predict_q        <= 1'b0;
            predict_target_q <= 32'd0;
            upd_count_q      <= 32'd0;
            mispred_count_q  <= 32'd0;
        end else begin
            pred_valid_q     <= pred_valid_d;
            predict_q        <= predict_d;
            predict_target_q <= predict_target_d;
            upd_count_q      <= upd_count_d;
            mispred_count_q  <= mispred_count_d;
        end
    end

    always_comb begin
        pred_valid     = pred_valid_q;
        predict        = predict_q;
        predict_target = predict_target_q;
        upd_count      = upd_count_q;
        mispred_count  = mispred_count_q;
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor (ENTRIES=64).
module tb_branch_predictor;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;
    localparam logic [31:0] Z     = 32'd0;
    localparam logic [31:0] P10   = 32'h0040_0010;
    localparam logic [31:0] P110  = 32'h0040_0110;
    localparam logic [31:0] P20   = 32'h0040_0020;
    localparam logic [31:0] P30   = 32'h0040_0030;
    localparam logic [31:0] P50   = 32'h0040_0050;
    localparam logic [31:0] P70   = 32'h0040_0070;
    localparam logic [31:0] T40   = 32'h0040_0040;
    localparam logic [31:0] T80   = 32'h0040_0080;
    localparam logic [31:0] T100  = 32'h0040_0100;
    localparam logic [31:0] T1000 = 32'h0040_1000;

    logic        clk = 1'b0;
    logic        rst, flush, lk_valid, lk_stall;
    logic [31:0] lk_pc;
    logic        pred_valid, predict, ready;
    logic [31:0] predict_target;
    logic        upd_valid, upd_taken, upd_uncond, upd_mispredict;
    logic [31:0] upd_pc, upd_target, upd_count, mispred_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk(clk), .rst(rst), .flush(flush),
        .lk_valid(lk_valid), .lk_stall(lk_stall), .lk_pc(lk_pc),
        .pred_valid(pred_valid), .predict(predict), .predict_target(predict_target),
        .ready(ready),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_uncond(upd_uncond), .upd_mispredict(upd_mispredict),
        .upd_count(upd_count), .mispred_count(mispred_count)
    );

    typedef struct {
        logic        lk_v;
        logic [31:0] lk_pc;
        logic        up_v;
        logic [31:0] up_pc;
        logic        tk;
        logic [31:0] tgt;
        logic        unc;
        logic        mis;
        logic        e_pv;
        logic        e_p;
        logic [31:0] e_tgt;
        logic [31:0] e_uc;
        logic [31:0] e_mc;
    } vec_t;

    vec_t vecs [29];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic unc, input logic mis);
        upd_valid = v; upd_pc = pc; upd_taken = tk;
        upd_target = tgt; upd_uncond = unc; upd_mispredict = mis;
    endtask

    initial begin
        // allocate / hysteresis
        vecs[0]  = '{Y, P10,  N, Z,    N, Z,     N, N, Y, N, Z,     32'd0,  32'd0};
        vecs[1]  = '{N, Z,    Y, P10,  Y, T40,   N, Y, N, N, Z,     32'd1,  32'd1};
        vecs[2]  = '{Y, P10,  N, Z,    N, Z,     N, N, Y, Y, T40,   32'd1,  32'd1};
        vecs[3]  = '{Y, P10,  Y, P10,  N, Z,     N, Y, Y, Y, T40,   32'd2,  32'd2};
        vecs[4]  = '{Y, P10,  Y, P10,  N, Z,     N, N, Y, N, Z,     32'd3,  32'd2};
        vecs[5]  = '{Y, P10,  N, Z,    N, Z,     N, N, Y, N, Z,     32'd3,  32'd2};
        vecs[6]  = '{Y, P10,  Y, P10,  Y, T40,   N, N, Y, N, Z,     32'd4,  32'd2};
        vecs[7]  = '{Y, P10,  Y, P10,  Y, T40,   N, N, Y, N, Z,     32'd5,  32'd2};
        vecs[8]  = '{Y, P10,  N, Z,    N, Z,     N, N, Y, Y, T40,   32'd5,  32'd2};
        vecs[9]  = '{Y, P10,  Y, P10,  Y, T40,   N, N, Y, Y, T40,   32'd6,  32'd2};
        vecs[10] = '{Y, P10,  Y, P10,  Y, T40,   N, N, Y, Y, T40,   32'd7,  32'd2};
        vecs[11] = '{Y, P10,  Y, P10,  Y, T40,   N, N, Y, Y, T40,   32'd8,  32'd2};
        vecs[12] = '{Y, P10,  Y, P10,  Y, T40,   N, N, Y, Y, T40,   32'd9,  32'd2};
        vecs[13] = '{Y, P10,  Y, P10,  Y, T40,   N, N, Y, Y, T40,   32'd10, 32'd2};
        vecs[14] = '{Y, P10,  Y, P10,  N, Z,     N, N, Y, Y, T40,   32'd11, 32'd2};
        vecs[15] = '{Y, P10,  N, Z,    N, Z,     N, N, Y, Y, T40,   32'd11, 32'd2};
        // aliasing on index 4
        vecs[16] = '{Y, P110, N, Z,    N, Z,     N, N, Y, N, Z,     32'd11, 32'd2};
        vecs[17] = '{N, Z,    Y, P110, Y, T1000, N, N, N, N, Z,     32'd12, 32'd2};
        vecs[18] = '{Y, P10,  N, Z,    N, Z,     N, N, Y, N, Z,     32'd12, 32'd2};
        vecs[19] = '{Y, P110, N, Z,    N, Z,     N, N, Y, Y, T1000, 32'd12, 32'd2};
        // same-cycle lookup and allocation: no forwarding
        vecs[20] = '{Y, P20,  Y, P20,  Y, T80,   N, N, Y, N, Z,     32'd13, 32'd2};
        vecs[21] = '{Y, P20,  N, Z,    N, Z,     N, N, Y, Y, T80,   32'd13, 32'd2};
        // unconditional allocation and its sticky flag
        vecs[22] = '{N, Z,    Y, P30,  N, T100,  Y, Y, N, N, Z,     32'd14, 32'd3};
        vecs[23] = '{Y, P30,  N, Z,    N, Z,     N, N, Y, Y, T100,  32'd14, 32'd3};
        vecs[24] = '{N, Z,    Y, P50,  N, T100,  N, N, N, N, Z,     32'd15, 32'd3};
        vecs[25] = '{Y, P50,  N, Z,    N, Z,     N, N, Y, N, Z,     32'd15, 32'd3};
        vecs[26] = '{N, Z,    Y, P30,  N, Z,     N, N, N, N, Z,     32'd16, 32'd3};
        vecs[27] = '{N, Z,    Y, P30,  N, Z,     N, N, N, N, Z,     32'd17, 32'd3};
        vecs[28] = '{Y, P30,  N, Z,    N, Z,     N, N, Y, Y, T100,  32'd17, 32'd3};

        rst = 1'b1; flush = 1'b0; lk_valid = 1'b1; lk_stall = 1'b0; lk_pc = P10;
        set_upd(N, Z, N, Z, N, N);

        // reset state
        tick(); tick();
        $display("txn reset");
        check("rst_pred_valid", 32'(pred_valid), 32'd0);
        check("rst_predict", 32'(predict), 32'd0);
        check("rst_target", predict_target, 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_upd_count", upd_count, 32'd0);
        check("rst_mispred_count", mispred_count, 32'd0);

        // INIT timing: ready after exactly 64 cycles; update in cycle 10 dropped
        rst = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            if (k == 10) set_upd(Y, P10, Y, T40, N, Y);
            else         set_upd(N, Z, N, Z, N, N);
            tick();
            check("init_ready", 32'(ready), (k == 64) ? 32'd1 : 32'd0);
            check("init_pred_valid", 32'(pred_valid), 32'd1);
            check("init_predict", 32'(predict), 32'd0);
        end
        $display("txn init done ready=%0d upd_count=%0d", ready, upd_count);
        check("init_upd_count", upd_count, 32'd0);
        check("init_mispred_count", mispred_count, 32'd0);

        for (int i = 0; i < 29; i++) begin
            lk_valid = vecs[i].lk_v; lk_pc = vecs[i].lk_pc;
            set_upd(vecs[i].up_v, vecs[i].up_pc, vecs[i].tk, vecs[i].tgt, vecs[i].unc, vecs[i].mis);
            tick();
            $display("txn vec %0d lk=%0d/%08h upd=%0d/%08h -> pv=%0d p=%0d tgt=%08h uc=%0d mc=%0d",
                     i, vecs[i].lk_v, vecs[i].lk_pc, vecs[i].up_v, vecs[i].up_pc,
                     pred_valid, predict, predict_target, upd_count, mispred_count);
            check($sformatf("vec%0d_pred_valid", i), 32'(pred_valid), 32'(vecs[i].e_pv));
            check($sformatf("vec%0d_predict", i), 32'(predict), 32'(vecs[i].e_p));
            check($sformatf("vec%0d_target", i), predict_target, vecs[i].e_tgt);
            check($sformatf("vec%0d_upd_count", i), upd_count, vecs[i].e_uc);
            check($sformatf("vec%0d_mispred_count", i), mispred_count, vecs[i].e_mc);
        end
        set_upd(N, Z, N, Z, N, N);

        // stall holds lookup outputs while pc/valid change
        lk_valid = 1'b1; lk_pc = P20;
        tick();
        check("prestall_predict", 32'(predict), 32'd1);
        for (int k = 0; k < 3; k++) begin
            lk_stall = 1'b1;
            lk_valid = (k != 1);
            lk_pc = (k == 0) ? P110 : ((k == 1) ? P50 : P10);
            tick();
            $display("txn stall %0d pv=%0d p=%0d tgt=%08h", k, pred_valid, predict, predict_target);
            check("stall_pred_valid", 32'(pred_valid), 32'd1);
            check("stall_predict", 32'(predict), 32'd1);
            check("stall_target", predict_target, T80);
        end
        lk_stall = 1'b0; lk_valid = 1'b0;
        tick();
        check("idle_pred_valid", 32'(pred_valid), 32'd0);
        check("idle_predict", 32'(predict), 32'd0);
        check("idle_target", predict_target, 32'd0);

        // flush wins over a same-cycle update
        flush = 1'b1;
        set_upd(Y, P70, Y, T100, N, Y);
        tick();
        flush = 1'b0;
        set_upd(N, Z, N, Z, N, N);
        $display("txn flush uc=%0d mc=%0d ready=%0d", upd_count, mispred_count, ready);
        check("flush_upd_count", upd_count, 32'd17);
        check("flush_mispred_count", mispred_count, 32'd3);
        check("flush_ready", 32'(ready), 32'd0);
        lk_valid = 1'b1; lk_pc = P20;
        for (int k = 1; k <= 64; k++) begin
            tick();
            check("reinit_ready", 32'(ready), (k == 64) ? 32'd1 : 32'd0);
            check("reinit_predict", 32'(predict), 32'd0);
        end
        tick();
        check("postflush_p20_predict", 32'(predict), 32'd0);
        lk_pc = P30;
        tick();
        check("postflush_p30_predict", 32'(predict), 32'd0);
        check("postflush_pred_valid", 32'(pred_valid), 32'd1);

        // reset mid-RUN returns everything to reset values
        rst = 1'b1;
        set_upd(Y, P10, Y, T40, N, Y);
        tick();
        $display("txn rst-in-run pv=%0d uc=%0d mc=%0d ready=%0d", pred_valid, upd_count, mispred_count, ready);
        check("rstrun_pred_valid", 32'(pred_valid), 32'd0);
        check("rstrun_upd_count", upd_count, 32'd0);
        check("rstrun_mispred_count", mispred_count, 32'd0);
        check("rstrun_ready", 32'(ready), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch target buffer with 2-bit saturating direction counters.
- Fetch side: produces the `predict` / `predict_target` pair that travels with each instruction down to the ALU.
- Resolve side: consumes the ALU's branch resolution (target = other[31:0], taken = other[32], mispredict = other[33]) to train entries.
- Includes a table-invalidation state machine and performance counters.

Parameters:
- ENTRIES, 64, number of BTB entries; power of two, minimum 4.
- IDX_W, $clog2(ENTRIES), index width (derived, not overridden).
- CTR_INIT, 2'b10, counter value written on allocation (weakly taken).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  one-cycle pulse; re-invalidates the whole table.
- lk_valid  input  1  fetch lookup request.
- lk_stall  input  1  fetch stalled; hold lookup outputs.
- lk_pc  input  32  fetch PC (word aligned).
- pred_valid  output  1  lookup outputs correspond to a request.
- predict  output  1  predicted taken.
- predict_target  output  32  predicted target; 0 when predict=0.
- ready  output  1  table initialised; low during INIT.
- upd_valid  input  1  resolved branch/jump leaving the ALU.
- upd_pc  input  32  PC of the resolved instruction.
- upd_taken  input  1  resolved direction (ALU other[32]).
- upd_target  input  32  resolved target (ALU other[31:0]).
- upd_uncond  input  1  j/jal/jr/jalr; always taken.
- upd_mispredict  input  1  ALU other[33].
- upd_count  output  32  resolved-update counter, wraps.
- mispred_count  output  32  mispredict counter, wraps.

Behaviour:

Address fields:
- index = pc[IDX_W+1:2].
- tag = pc[31:IDX_W+2].
- Entry fields: valid, tag, target[31:2], ctr[1:0], uncond.

State machine, states INIT and RUN:
- rst or flush: go to INIT; the index counter clears to 0.
- INIT: clears valid of one entry per cycle. After ENTRIES cycles, go to RUN with ready=1.
- ready rises on the cycle after the last entry is cleared, i.e. exactly ENTRIES cycles after rst deasserts.
- flush while already in INIT restarts the count from 0.
- rst mid-RUN: all outputs return to reset values on the next edge. Table contents are irrelevant because INIT re-invalidates them.

Reset values:
- pred_valid=0, predict=0, predict_target=0, ready=0, upd_count=0, mispred_count=0, state=INIT.

Lookup (1-cycle latency, registered outputs):
- If lk_valid and not lk_stall at edge t:
  - pred_valid=1 at t+1.
  - predict = hit & (ctr[1] | uncond).
  - predict_target = predict ? {target,2'b00} : 0.
- hit = RUN & valid & tag match.
- If lk_stall: all lookup outputs hold their values.
- If not lk_valid and not lk_stall: pred_valid=0, predict=0, predict_target=0.
- In INIT, a lookup yields pred_valid=1, predict=0.

Update (applied at the edge of the cycle upd_valid is high; RUN only):
- Updates in INIT are dropped and are not counted.
- Hit, conditional branch:
  - ctr saturating +1 if taken, -1 if not.
  - If taken, target := upd_target[31:2].
- Hit, unconditional: target := upd_target[31:2]; ctr := 2'b11.
- Miss and (taken | uncond): allocate (overwrites any alias).
  - valid=1, tag, target.
  - ctr = uncond ? 2'b11 : CTR_INIT.
  - uncond flag recorded.
- Miss and not taken: no change.
- Counters: upd_count += 1; mispred_count += upd_mispredict; both wrap at 2^32.

Simultaneous events:
- Lookup and update in the same cycle on the same index: the lookup sees pre-update contents. No forwarding.
- flush and upd_valid in the same cycle: flush wins; the update is dropped and not counted.
- rst has priority over everything.

Decomposition:
- Shared package / defs.h additions:
  - Counter encodings: CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3.
  - BP state codes: BP_INIT, BP_RUN.
- One natural sub-module: bp_sat_ctr, a combinational 2-bit saturating next-value function (inputs ctr, taken).
- Table storage stays as flop arrays inside branch_predictor.

Test Plan:
- Init timing:
  - Stimulus: deassert rst, ENTRIES=64, issue lk_valid every cycle.
  - Required: ready=0 for 64 cycles, then 1; every pred_valid=1 result has predict=0; an upd_valid in cycle 10 leaves upd_count=0.
- Allocate and hit:
  - Stimulus: update pc=0x00400010, taken=1, target=0x00400040.
  - Required: next lookup of 0x00400010 gives predict=1, predict_target=0x00400040; upd_count=1.
- Counter hysteresis:
  - Stimulus: after allocation (ctr=2), apply two not-taken updates.
  - Required: predict=0.
  - Stimulus: then one taken update. Required: predict still 0 (ctr=1).
  - Stimulus: then another taken update. Required: predict=1.
  - Stimulus: then five taken updates followed by one not-taken. Required: predict=1 (ctr saturated at 3, back to 2).
- Aliasing:
  - Stimulus: entry at 0x00400010 (index 4); look up 0x00400110 (index 4, different tag).
  - Required: predict=0.
  - Stimulus: taken update at 0x00400110, target 0x00401000.
  - Required: 0x00400010 now misses.
- Same-cycle lookup/update:
  - Stimulus: lookup 0x00400020 while allocating 0x00400020 in the same cycle.
  - Required: predict=0; a repeat lookup gives predict=1.
- Stall hold, flush and counters:
  - Stimulus: assert lk_stall for 3 cycles while lk_pc changes. Required: outputs unchanged.
  - Stimulus: flush together with upd_valid and upd_mispredict=1. Required: update dropped, mispred_count unchanged, ready=0 for 64 cycles, previously allocated PCs miss.
